// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 1bpp framebuffer with 640x480 VGA scanout,
// 2x pixel doubling and a hardware full-screen clear.
//
// Ports: clk_i, rstn_i (async, active-low)
//   write side : wr_valid_i/wr_ready_o, wr_x_i, wr_y_i, wr_color_i,
//                clr_i, busy_o, drop_o
//   video side : fg_color_i, bg_color_i, vga_hs_o, vga_vs_o,
//                rgb_o, frame_start_o
module vga_fb_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_DIV     = 2,
  parameter int SCALE_SHIFT = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [10:0] wr_x_i,
  input  logic [10:0] wr_y_i,
  input  logic        wr_color_i,
  input  logic        clr_i,
  output logic        busy_o,
  output logic        drop_o,
  input  logic [11:0] fg_color_i,
  input  logic [11:0] bg_color_i,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic [11:0] rgb_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H    = V_ACTIVE >> SCALE_SHIFT;
  localparam int FB_N    = FB_W * FB_H;
  localparam int AW      = $clog2(FB_N);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(PIX_DIV);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW-1:0] A_LAST  = AW'(FB_N - 1);
  localparam logic [AW-1:0] A_W     = AW'(FB_W);

  typedef enum logic { S_IDLE, S_CLEAR } state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;

  logic          in_range;
  logic          accept;
  logic [AW-1:0] wr_addr;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic          mem_wd;

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          tick;
  logic          act0, hs0, vs0, fs0;
  logic [AW-1:0] rd_addr;

  logic          act1, hs1, vs1, fs1;
  logic          rd_bit;

  logic          mem [FB_N];

  // ---------------- write / clear ----------------
  assign in_range   = (wr_x_i < 11'(FB_W)) &&
                      (wr_y_i < 11'(FB_H));
  assign wr_ready_o = (state == S_IDLE) && !clr_i;
  assign accept     = wr_valid_i && wr_ready_o;
  assign wr_addr    = AW'(wr_y_i) * A_W + AW'(wr_x_i);

  assign mem_we = (state == S_CLEAR) ||
                  (accept && in_range);
  assign mem_wa = (state == S_CLEAR) ? clr_cnt : wr_addr;
  assign mem_wd = (state == S_IDLE) && wr_color_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      busy_o  <= 1'b0;
      drop_o  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          drop_o <= accept && !in_range;
          if (clr_i) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            busy_o  <= 1'b1;
          end
        end
        S_CLEAR: begin
          drop_o <= 1'b0;
          if (clr_cnt == A_LAST) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- framebuffer ----------------
  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
    if (act0)
      rd_bit <= mem[rd_addr];
  end

  // ---------------- timing counters ----------------
  assign tick = (div == D_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else if (tick) begin
      div <= '0;
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  assign act0 = (h < HW'(H_ACTIVE)) &&
                (v < VW'(V_ACTIVE));
  assign hs0  = !((h >= HS_BEG) && (h < HS_END));
  assign vs0  = !((v >= VS_BEG) && (v < VS_END));
  assign fs0  = tick && (h == '0) && (v == '0);

  assign rd_addr = AW'(v >> SCALE_SHIFT) * A_W +
                   AW'(h >> SCALE_SHIFT);

  // ---------------- pipeline ----------------
  // Sync and frame-start travel alongside the RAM read so
  // every video output lands on the same edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      act1 <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      fs1  <= 1'b0;
    end else begin
      act1 <= act0;
      hs1  <= hs0;
      vs1  <= vs0;
      fs1  <= fs0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rgb_o         <= '0;
      vga_hs_o      <= 1'b1;
      vga_vs_o      <= 1'b1;
      frame_start_o <= 1'b0;
    end else begin
      rgb_o         <= act1 ? (rd_bit ? fg_color_i
                                      : bg_color_i)
                            : '0;
      vga_hs_o      <= hs1;
      vga_vs_o      <= vs1;
      frame_start_o <= fs1;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: randomized self-checking bench for
// vga_fb_scanout on a shrunken screen geometry.
module tb_vga_fb_scanout;

  localparam int HA = 32, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 16, VF = 2, VSY = 2, VB = 3;
  localparam int PD = 2, S = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FBW = HA >> S, FBH = VA >> S;
  localparam int FBN = FBW * FBH;
  localparam int LINE = HT * PD;
  localparam int FRAME = LINE * VT;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        wr_valid_i, wr_ready_o;
  logic [10:0] wr_x_i, wr_y_i;
  logic        wr_color_i, clr_i, busy_o, drop_o;
  logic [11:0] fg, bg, rgb_o;
  logic        vga_hs_o, vga_vs_o, frame_start_o;

  int tests = 0;
  int fails = 0;
  int cyc;
  bit fb [FBN];

  always #5 clk_i = ~clk_i;

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .PIX_DIV(PD), .SCALE_SHIFT(S)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_x_i(wr_x_i), .wr_y_i(wr_y_i),
    .wr_color_i(wr_color_i), .clr_i(clr_i),
    .busy_o(busy_o), .drop_o(drop_o),
    .fg_color_i(fg), .bg_color_i(bg),
    .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o),
    .rgb_o(rgb_o), .frame_start_o(frame_start_o)
  );

  // clock edges since reset release
  always @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) cyc <= 0;
    else         cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  // Screen output expected m edges after reset release.
  function automatic void model(input int m,
    output logic e_hs, output logic e_vs,
    output logic e_fs, output logic [11:0] e_rgb,
    output bit act);
    int j, p, hh, vv;
    e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    e_rgb = '0; act = 1'b0;
    if (m >= 2) begin
      j  = m - 2;
      p  = j / PD;
      hh = p % HT;
      vv = (p / HT) % VT;
      act  = (hh < HA) && (vv < VA);
      e_hs = !(hh >= HA + HF && hh < HA + HF + HSY);
      e_vs = !(vv >= VA + VF && vv < VA + VF + VSY);
      e_fs = (j % PD == PD - 1) && hh == 0 && vv == 0;
      if (act)
        e_rgb = fb[(vv >> S) * FBW + (hh >> S)] ? fg : bg;
    end
  endfunction

  task automatic scan(input int n, input bit pix,
    output int bad, output int nfg, output string first);
    logic e_hs, e_vs, e_fs;
    logic [11:0] e_rgb;
    bit act, ok;
    bad = 0; nfg = 0; first = "none";
    repeat (n) begin
      @(negedge clk_i);
      model(cyc, e_hs, e_vs, e_fs, e_rgb, act);
      ok = (vga_hs_o === e_hs) && (vga_vs_o === e_vs) &&
           (frame_start_o === e_fs);
      if (pix || !act) ok = ok && (rgb_o === e_rgb);
      if (rgb_o === fg) nfg++;
      if (!ok) begin
        if (bad == 0)
          first = $sformatf(
            "cyc %0d hs,vs,fs,rgb=%b%b%b %h need %b%b%b %h",
            cyc, vga_hs_o, vga_vs_o, frame_start_o, rgb_o,
            e_hs, e_vs, e_fs, e_rgb);
        bad++;
      end
    end
  endtask

  task automatic do_write(input int x, input int y,
    input bit c, output bit rdy, output bit d1,
    output bit d2);
    @(negedge clk_i);
    wr_valid_i = 1'b1;
    wr_x_i = 11'(x); wr_y_i = 11'(y); wr_color_i = c;
    #1 rdy = wr_ready_o;
    @(posedge clk_i);
    if (x < FBW && y < FBH) fb[y * FBW + x] = c;
    @(negedge clk_i);
    wr_valid_i = 1'b0;
    d1 = drop_o;
    @(negedge clk_i);
    d2 = drop_o;
  endtask

  task automatic do_clear(output int n);
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 4 * FBN) begin
      n++;
      @(negedge clk_i);
    end
    for (int i = 0; i < FBN; i++) fb[i] = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++;
    if ({vga_hs_o, vga_vs_o, frame_start_o} !== 3'b110) begin
      fails++;
      $display("FAIL reset_sync: hs,vs,fs=%b%b%b need 110",
               vga_hs_o, vga_vs_o, frame_start_o);
    end
    tests++;
    if (rgb_o !== 12'h000) begin
      fails++;
      $display("FAIL reset_rgb: %h need 000", rgb_o);
    end
    tests++;
    if ({busy_o, drop_o, wr_ready_o} !== 3'b001) begin
      fails++;
      $display("FAIL reset_ctrl: busy,drop,rdy=%b%b%b need 001",
               busy_o, drop_o, wr_ready_o);
    end
    rstn_i = 1'b1;
  endtask

  task automatic test_sync();
    int hf[2], vf[2], ft[2];
    int hr, vr, nh, nv, nf;
    logic ph, pv;
    hf = '{-1, -1}; vf = '{-1, -1}; ft = '{-1, -1};
    hr = -1; vr = -1; nh = 0; nv = 0; nf = 0;
    ph = 1'b1; pv = 1'b1;
    repeat (2 * FRAME + LINE) begin
      @(negedge clk_i);
      if (ph && !vga_hs_o) begin
        if (nh < 2) hf[nh] = cyc;
        nh++;
      end
      if (!ph && vga_hs_o && hr < 0 && nh > 0) hr = cyc;
      if (pv && !vga_vs_o) begin
        if (nv < 2) vf[nv] = cyc;
        nv++;
      end
      if (!pv && vga_vs_o && vr < 0 && nv > 0) vr = cyc;
      if (frame_start_o) begin
        if (nf < 2) ft[nf] = cyc;
        nf++;
      end
      ph = vga_hs_o; pv = vga_vs_o;
    end
    tests++;
    if (hf[1] - hf[0] !== LINE || hf[0] < 0) begin
      fails++;
      $display("FAIL hs_period: %0d need %0d", hf[1] - hf[0], LINE);
    end
    tests++;
    if (hr - hf[0] !== HSY * PD || hr < 0) begin
      fails++;
      $display("FAIL hs_width: %0d need %0d", hr - hf[0], HSY * PD);
    end
    tests++;
    if (vf[1] - vf[0] !== FRAME || vf[0] < 0) begin
      fails++;
      $display("FAIL vs_period: %0d need %0d", vf[1] - vf[0], FRAME);
    end
    tests++;
    if (vr - vf[0] !== VSY * LINE || vr < 0) begin
      fails++;
      $display("FAIL vs_width: %0d need %0d", vr - vf[0], VSY * LINE);
    end
    tests++;
    if (ft[1] - ft[0] !== FRAME || ft[0] !== 3) begin
      fails++;
      $display("FAIL frame_start: first %0d period %0d need 3 %0d",
               ft[0], ft[1] - ft[0], FRAME);
    end
  endtask

  task automatic test_blank();
    int bad, nfg;
    string first;
    scan(FRAME, 1'b0, bad, nfg, first);
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL blank_scan: %0d bad cycles need 0, %s", bad, first);
    end
  endtask

  task automatic test_pixel();
    int n, bad, nfg;
    bit rdy, d1, d2;
    string first;
    do_clear(n);
    fg = 12'hF00; bg = 12'h00F;
    do_write(5, 3, 1'b1, rdy, d1, d2);
    tests++;
    if ({rdy, d1, d2} !== 3'b100) begin
      fails++;
      $display("FAIL pixel_write: rdy,drop,drop=%b%b%b need 100",
               rdy, d1, d2);
    end
    repeat (4) @(negedge clk_i);
    scan(FRAME, 1'b1, bad, nfg, first);
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL pixel_scan: %0d bad cycles need 0, %s", bad, first);
    end
    tests++;
    if (nfg !== 4 * PD) begin
      fails++;
      $display("FAIL pixel_fg_count: %0d need %0d", nfg, 4 * PD);
    end
  endtask

  task automatic test_out_of_range();
    int bad, nfg;
    bit rdy, d1, d2, r2, e1, e2;
    string first;
    do_write(FBW, 0, 1'b1, rdy, d1, d2);
    do_write(0, FBH, 1'b1, r2, e1, e2);
    tests++;
    if ({rdy, d1, d2, r2, e1, e2} !== 6'b110110) begin
      fails++;
      $display("FAIL oor_drop: rdy,drop,drop x2=%b%b%b %b%b%b need 110 110",
               rdy, d1, d2, r2, e1, e2);
    end
    repeat (4) @(negedge clk_i);
    scan(FRAME, 1'b1, bad, nfg, first);
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL oor_scan: %0d bad cycles need 0, %s", bad, first);
    end
  endtask

  task automatic test_random_writes();
    int x, y, bad, nfg, wbad;
    bit c, rdy, d1, d2, oor;
    string first;
    fg = 12'($urandom); bg = 12'($urandom);
    wbad = 0;
    for (int i = 0; i < 40; i++) begin
      x = $urandom_range(FBW + 3);
      y = $urandom_range(FBH + 2);
      c = 1'($urandom);
      oor = (x >= FBW) || (y >= FBH);
      do_write(x, y, c, rdy, d1, d2);
      if ({rdy, d1, d2} !== {1'b1, oor, 1'b0}) wbad++;
    end
    tests++;
    if (wbad !== 0) begin
      fails++;
      $display("FAIL rand_write_hs: %0d bad writes need 0", wbad);
    end
    repeat (4) @(negedge clk_i);
    scan(FRAME, 1'b1, bad, nfg, first);
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL rand_scan: %0d bad cycles need 0, %s", bad, first);
    end
  endtask

  task automatic test_clear();
    int n, bad, nfg, rbad;
    bit rdy, d1, d2;
    string first;
    fg = 12'($urandom) | 12'h001;
    bg = fg ^ 12'hFFF;
    for (int i = 0; i < FBN; i++)
      do_write(i % FBW, i / FBW, 1'b1, rdy, d1, d2);
    repeat (4) @(negedge clk_i);
    scan(FRAME, 1'b1, bad, nfg, first);
    tests++;
    if (bad !== 0 || nfg !== HA * VA * PD) begin
      fails++;
      $display("FAIL fill_scan: bad %0d fg %0d need 0 %0d, %s",
               bad, nfg, HA * VA * PD, first);
    end
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    n = 0; rbad = 0;
    while (busy_o === 1'b1 && n < 4 * FBN) begin
      n++;
      if (wr_ready_o !== 1'b0) rbad++;
      clr_i = (n == 50);
      @(negedge clk_i);
    end
    clr_i = 1'b0;
    for (int i = 0; i < FBN; i++) fb[i] = 1'b0;
    tests++;
    if (n !== FBN) begin
      fails++;
      $display("FAIL clear_busy_len: %0d need %0d", n, FBN);
    end
    tests++;
    if (rbad !== 0) begin
      fails++;
      $display("FAIL clear_ready: high %0d cycles need 0", rbad);
    end
    repeat (4) @(negedge clk_i);
    scan(FRAME, 1'b1, bad, nfg, first);
    tests++;
    if (bad !== 0 || nfg !== 0) begin
      fails++;
      $display("FAIL clear_scan: bad %0d fg %0d need 0 0, %s",
               bad, nfg, first);
    end
  endtask

  task automatic test_priority();
    bit rdy, d1, b1;
    int n;
    @(negedge clk_i);
    clr_i = 1'b1; wr_valid_i = 1'b1;
    wr_x_i = 11'(FBW); wr_y_i = 11'd0; wr_color_i = 1'b1;
    #1 rdy = wr_ready_o;
    @(negedge clk_i);
    clr_i = 1'b0; wr_valid_i = 1'b0;
    d1 = drop_o; b1 = busy_o;
    tests++;
    if ({rdy, d1, b1} !== 3'b001) begin
      fails++;
      $display("FAIL priority: rdy,drop,busy=%b%b%b need 001",
               rdy, d1, b1);
    end
    n = 0;
    while (busy_o === 1'b1 && n < 4 * FBN) begin
      n++;
      @(negedge clk_i);
    end
    for (int i = 0; i < FBN; i++) fb[i] = 1'b0;
    tests++;
    if (n !== FBN) begin
      fails++;
      $display("FAIL priority_busy_len: %0d need %0d", n, FBN);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n, t, bad, nfg;
    string first;
    fg = 12'hFFF; bg = 12'hFFF;
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    repeat (100) @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    tests++;
    if ({busy_o, vga_hs_o, vga_vs_o, frame_start_o, rgb_o}
        !== {4'b0110, 12'h000}) begin
      fails++;
      $display("FAIL rst_mid: busy,hs,vs,fs=%b%b%b%b rgb %h need 0110 000",
               busy_o, vga_hs_o, vga_vs_o, frame_start_o, rgb_o);
    end
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    t = -1; n = 0;
    while (t < 0 && n < 2 * FRAME) begin
      @(negedge clk_i);
      n++;
      if (frame_start_o === 1'b1) t = cyc;
    end
    tests++;
    if (t !== 3 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_restart: first fs at %0d busy %b need 3 0",
               t, busy_o);
    end
    scan(FRAME, 1'b0, bad, nfg, first);
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL rst_scan: %0d bad cycles need 0, %s", bad, first);
    end
  endtask

  initial begin
    wr_valid_i = 1'b0; wr_x_i = '0; wr_y_i = '0;
    wr_color_i = 1'b0; clr_i = 1'b0;
    fg = 12'hABC; bg = 12'h123;
    test_reset();
    test_sync();
    test_blank();
    test_pixel();
    test_out_of_range();
    test_random_writes();
    test_clear();
    test_priority();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
# vga_fb_scanout

Downstream display stage of the VGA peripheral. It holds a 1-bit-per-pixel framebuffer that is filled by single-pixel write requests from the APB register wrapper (x, y, colour bit, write strobe). It generates 640x480@60 VGA timing and scans the framebuffer out as 12-bit RGB, doubling every stored pixel horizontally and vertically. It also provides a hardware full-screen clear so software never has to loop over the buffer.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL 800)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (V_TOTAL 525)
- PIX_DIV, 2, clk_i cycles per pixel (min 2); clk_i 50 MHz gives a 25 MHz pixel rate
- SCALE_SHIFT, 1, framebuffer is (H_ACTIVE>>S) x (V_ACTIVE>>S) = 320x240 bits

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- wr_valid_i  in  1  pixel write request
- wr_ready_o  out  1  write accepted when wr_valid_i & wr_ready_o
- wr_x_i  in  11  framebuffer column
- wr_y_i  in  11  framebuffer row
- wr_color_i  in  1  pixel bit (1 = foreground)
- clr_i  in  1  single-cycle clear request
- busy_o  out  1  clear in progress
- drop_o  out  1  one-cycle pulse when an accepted write was out of range
- fg_color_i  in  12  RGB for bit 1
- bg_color_i  in  12  RGB for bit 0
- vga_hs_o  out  1  horizontal sync, active low
- vga_vs_o  out  1  vertical sync, active low
- rgb_o  out  12  pixel colour, 0 during blanking
- frame_start_o  out  1  one-cycle pulse aligned with output of pixel (0,0)

## Operation
- Framebuffer: simple dual-port RAM of FB_W*FB_H bits. The write port is owned by the write/clear FSM; the read port is owned by scanout. Contents are not reset.
- Address: addr = y*FB_W + x, with width clog2(FB_W*FB_H) (17 bits). The multiply is by a constant.
- FSM states: IDLE, CLEAR.
  - IDLE: wr_ready_o = ~clr_i. An accepted write with x<FB_W and y<FB_H writes wr_color_i. An accepted write with x>=FB_W or y>=FB_H is discarded, and drop_o pulses on the next cycle.
  - IDLE -> CLEAR on clr_i. Clear takes priority: a simultaneous write is not accepted.
  - CLEAR: writes 0 to addresses 0..N-1, one per clk_i (N = 76800 cycles). wr_ready_o = 0 and busy_o = 1. clr_i is ignored. Returns to IDLE after address N-1 is written.
- Scanout:
  - Divider counter div runs 0..PIX_DIV-1; tick = (div == PIX_DIV-1).
  - On tick, h advances 0..H_TOTAL-1 and wraps. v advances on h wrap, 0..V_TOTAL-1, and wraps.
  - Read address = (v>>S)*FB_W + (h>>S), issued only when h<H_ACTIVE and v<V_ACTIVE.
- Output rules:
  - Active region: rgb_o = bit ? fg_color_i : bg_color_i. Colours are sampled at the output stage and may change at any time.
  - Blanking: rgb_o = 0.
  - vga_hs_o = 0 when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vga_vs_o = 0 when 490 <= v < 492.
- Read/write collision on the same address in the same cycle: the read returns either old or new data. This is accepted and is not a bench error.

## Timing
- Reset values: vga_hs_o=1, vga_vs_o=1, rgb_o=0, busy_o=0, drop_o=0, frame_start_o=0. Also: div=0, h=0, v=0, FSM=IDLE, wr_ready_o=1 while clr_i=0.
- Write latency: the RAM is updated on the accepting edge. The write is visible to scanout from the next frame position it reaches.
- Scanout pipeline, 2 clk_i deep: counters, then RAM read register, then output register.
  - vga_hs_o, vga_vs_o, rgb_o and frame_start_o all update on the same edge, so sync and colour never skew.
- Line period is H_TOTAL*PIX_DIV = 1600 clk_i. HS low lasts 192 clk_i.
- Frame period is 525*1600 = 840000 clk_i. VS low lasts 3200 clk_i.
- Reset during CLEAR: the FSM returns to IDLE and busy_o drops asynchronously. The buffer is left partially cleared, and no completion is signalled.
- Reset mid-line: counters restart at (0,0). The first frame_start_o comes 2 clk_i after the first tick with h=v=0 following reset release.

## Test plan
- Sync timing: run 2 frames after reset -> HS period 1600 and low width 192; VS period 840000 and low width 3200; frame_start_o period 840000; rgb_o = 0 whenever h>=640 or v>=480.
- Pixel write: clear, then write (x=5, y=3, bit=1) with fg=12'hF00 and bg=12'h00F -> rgb_o = F00 exactly for screen pixels h=10..11, v=6..7; all other active pixels = 00F.
- Out-of-range write: wr_x_i=320, y=0 -> accepted, drop_o pulses once, and the framebuffer is unchanged (full frame compare).
- Clear: fill the buffer with 1s, pulse clr_i -> busy_o high for exactly 76800 cycles and wr_ready_o low throughout; next frame shows all bg.
- Priority: clr_i and wr_valid_i in the same cycle -> wr_ready_o=0 and the write is not accepted; a clr_i pulse during CLEAR does not extend busy_o.
- Reset mid-clear: assert rstn_i at clear cycle 1000 -> busy_o=0, HS/VS=1 and rgb_o=0 immediately; after release, timing restarts at (0,0).
